// File: rtl/stall_unit.sv
// rtl/stall_unit.sv - decode-stage hazard/stall controller with MDU busy window
// Compares D sources against E/M destinations by Tuse/Tnew and tracks HI/LO busy time.
module stall_unit #(
  parameter int MULT_CYCLES = 5,
  parameter int DIV_CYCLES  = 10,
  parameter int CNT_W       = 4,
  parameter int STALL_CNT_W = 32
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic [31:0]            IR_D,
  input  logic [31:0]            IR_E,
  input  logic [31:0]            IR_M,
  output logic                   Stop,
  output logic                   md_busy,
  output logic [STALL_CNT_W-1:0] stall_cnt
);

  typedef enum logic [3:0] {
    C_NONE, C_CAL_R, C_JR, C_JALR, C_MD, C_MF, C_MT,
    C_CAL_I, C_LW, C_SW, C_BEQ, C_J, C_JAL
  } cls_t;

  // Tuse of 3 marks an operand that is not read; Tnew never exceeds 2.
  localparam logic [1:0] NO_USE = 2'd3;

  function automatic cls_t classify(input logic [5:0] op, input logic [5:0] fn);
    cls_t c;
    c = C_NONE;
    if (op == 6'b000000) begin
      case (fn)
        6'b100001, 6'b100011:                       c = C_CAL_R;
        6'b001000:                                  c = C_JR;
        6'b001001:                                  c = C_JALR;
        6'b011000, 6'b011001, 6'b011010, 6'b011011: c = C_MD;
        6'b010000, 6'b010010:                       c = C_MF;
        6'b010001, 6'b010011:                       c = C_MT;
        default:                                    c = C_NONE;
      endcase
    end else begin
      case (op)
        6'b001101, 6'b001111: c = C_CAL_I;
        6'b100011:            c = C_LW;
        6'b101011:            c = C_SW;
        6'b000100:            c = C_BEQ;
        6'b000010:            c = C_J;
        6'b000011:            c = C_JAL;
        default:              c = C_NONE;
      endcase
    end
    return c;
  endfunction

  function automatic logic [1:0] tuse_rs(input cls_t c);
    case (c)
      C_BEQ, C_JR, C_JALR:                    return 2'd0;
      C_CAL_R, C_CAL_I, C_LW, C_SW, C_MD, C_MT: return 2'd1;
      default:                                return NO_USE;
    endcase
  endfunction

  function automatic logic [1:0] tuse_rt(input cls_t c);
    case (c)
      C_BEQ:         return 2'd0;
      C_CAL_R, C_MD: return 2'd1;
      C_SW:          return 2'd2;
      default:       return NO_USE;
    endcase
  endfunction

  function automatic logic [4:0] dest_of(input cls_t c, input logic [4:0] rt, input logic [4:0] rd);
    case (c)
      C_CAL_R, C_JALR, C_MF: return rd;
      C_CAL_I, C_LW:         return rt;
      C_JAL:                 return 5'd31;
      default:               return 5'd0;
    endcase
  endfunction

  function automatic logic [1:0] tnew_e(input cls_t c);
    case (c)
      C_LW:                   return 2'd2;
      C_CAL_R, C_CAL_I, C_MF: return 2'd1;
      default:                return 2'd0;
    endcase
  endfunction

  function automatic logic [1:0] tnew_m(input cls_t c);
    return (c == C_LW) ? 2'd1 : 2'd0;
  endfunction

  function automatic logic hazard(input logic [4:0] src, input logic [1:0] tuse,
                                  input logic [4:0] dest, input logic [1:0] tnew);
    return (src != 5'd0) && (src == dest) && (tnew > tuse);
  endfunction

  cls_t             cls_d, cls_e, cls_m;
  logic [4:0]       rs_d, rt_d, dest_e, dest_m;
  logic [1:0]       use_rs, use_rt, new_e, new_m;
  logic             reg_stall, md_stall;
  logic [CNT_W-1:0] cnt;
  logic             unused_ir;

  assign cls_d  = classify(IR_D[31:26], IR_D[5:0]);
  assign cls_e  = classify(IR_E[31:26], IR_E[5:0]);
  assign cls_m  = classify(IR_M[31:26], IR_M[5:0]);
  assign rs_d   = IR_D[25:21];
  assign rt_d   = IR_D[20:16];
  assign use_rs = tuse_rs(cls_d);
  assign use_rt = tuse_rt(cls_d);
  assign dest_e = dest_of(cls_e, IR_E[20:16], IR_E[15:11]);
  assign dest_m = dest_of(cls_m, IR_M[20:16], IR_M[15:11]);
  assign new_e  = tnew_e(cls_e);
  assign new_m  = tnew_m(cls_m);

  // Shamt/immediate bits play no part in hazard detection.
  assign unused_ir = ^{IR_D, IR_E, IR_M};

  assign reg_stall = hazard(rs_d, use_rs, dest_e, new_e) ||
                     hazard(rs_d, use_rs, dest_m, new_m) ||
                     hazard(rt_d, use_rt, dest_e, new_e) ||
                     hazard(rt_d, use_rt, dest_m, new_m);

  assign md_busy  = (cnt != '0);
  assign md_stall = md_busy && (cls_d == C_MD || cls_d == C_MF || cls_d == C_MT);
  assign Stop     = reg_stall || md_stall;

  always_ff @(posedge clk) begin
    if (reset) begin
      cnt       <= '0;
      stall_cnt <= '0;
    end else begin
      // An issuing md_start always sees cnt==0, so load and decrement never collide.
      if (cls_d == C_MD && !Stop) begin
        cnt <= (IR_D[1] ? CNT_W'(DIV_CYCLES) : CNT_W'(MULT_CYCLES));
      end else if (cnt != '0) begin
        cnt <= cnt - 1'b1;
      end
      if (Stop && stall_cnt != '1) begin
        stall_cnt <= stall_cnt + 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_stall_unit.sv
// tb/tb_stall_unit.sv - directed self-checking bench for stall_unit
module tb_stall_unit;

  logic        clk = 1'b0;
  logic        reset;
  logic [31:0] IR_D, IR_E, IR_M;
  logic        Stop, md_busy;
  logic [3:0]  stall_cnt;

  int pass_cnt = 0;
  int total_cnt = 0;

  stall_unit #(
    .MULT_CYCLES(5), .DIV_CYCLES(10), .CNT_W(4), .STALL_CNT_W(4)
  ) dut (
    .clk(clk), .reset(reset), .IR_D(IR_D), .IR_E(IR_E), .IR_M(IR_M),
    .Stop(Stop), .md_busy(md_busy), .stall_cnt(stall_cnt)
  );

  always #5 clk = ~clk;

  localparam logic [31:0] NOP = 32'd0;

  function automatic logic [31:0] r_op(input int rs, input int rt, input int rd, input logic [5:0] fn);
    return {6'd0, 5'(rs), 5'(rt), 5'(rd), 5'd0, fn};
  endfunction

  function automatic logic [31:0] i_op(input logic [5:0] op, input int rs, input int rt, input logic [15:0] imm);
    return {op, 5'(rs), 5'(rt), imm};
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_ir(input logic [31:0] d, input logic [31:0] e, input logic [31:0] m);
    IR_D = d; IR_E = e; IR_M = m;
    #1;
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total_cnt++;
    if (act !== exp) $display("FAIL %s: got %0d expected %0d", name, act, exp);
    else pass_cnt++;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    set_ir(NOP, NOP, NOP);
    tick();
    tick();
    reset = 1'b0;
  endtask

  // Counts consecutive Stop=1 cycles for the current IR_D, bounded to 30.
  task automatic count_stalls(output int n);
    n = 0;
    for (int i = 0; i < 30; i++) begin
      if (!Stop) break;
      n++;
      tick();
    end
  endtask

  task automatic test_reset();
    do_reset();
    chk("reset_md_busy", 32'(md_busy), 0);
    chk("reset_stall_cnt", 32'(stall_cnt), 0);
    chk("reset_stop", 32'(Stop), 0);
  endtask

  task automatic test_load_use();
    set_ir(r_op(8, 1, 9, 6'b100001), i_op(6'b100011, 0, 8, 0), NOP);
    chk("load_use_E", 32'(Stop), 1);
    set_ir(r_op(8, 1, 9, 6'b100001), NOP, i_op(6'b100011, 0, 8, 0));
    chk("load_use_M", 32'(Stop), 0);
  endtask

  task automatic test_branch();
    set_ir(i_op(6'b000100, 5, 0, 16'd4), NOP, i_op(6'b100011, 0, 5, 0));
    chk("beq_lw_M", 32'(Stop), 1);
    set_ir(i_op(6'b000100, 5, 0, 16'd4), NOP, i_op(6'b001101, 0, 5, 16'd1));
    chk("beq_ori_M", 32'(Stop), 0);
    set_ir(i_op(6'b000100, 0, 5, 16'd4), i_op(6'b001101, 0, 5, 16'd1), NOP);
    chk("beq_rt_ori_E", 32'(Stop), 1);
    set_ir(r_op(31, 0, 0, 6'b001000), {6'b000011, 26'd16}, NOP);
    chk("jr_jal_E", 32'(Stop), 0);
  endtask

  task automatic test_store_zero();
    set_ir(i_op(6'b101011, 2, 4, 0), i_op(6'b100011, 0, 4, 0), NOP);
    chk("sw_data_lw_E", 32'(Stop), 0);
    set_ir(i_op(6'b101011, 4, 2, 0), i_op(6'b100011, 0, 4, 0), NOP);
    chk("sw_base_lw_E", 32'(Stop), 1);
    set_ir(r_op(0, 0, 0, 6'b001000), i_op(6'b001101, 0, 0, 16'd1), NOP);
    chk("jr_zero", 32'(Stop), 0);
  endtask

  task automatic test_mdu_window();
    int n;
    do_reset();
    set_ir(r_op(2, 3, 0, 6'b011010), NOP, NOP);
    chk("div_issue_stop", 32'(Stop), 0);
    tick();
    chk("div_busy", 32'(md_busy), 1);
    set_ir(r_op(0, 0, 7, 6'b010010), r_op(2, 3, 0, 6'b011010), NOP);
    count_stalls(n);
    chk("div_mflo_stalls", n, 10);
    chk("div_busy_end", 32'(md_busy), 0);
    set_ir(r_op(2, 3, 0, 6'b011000), NOP, NOP);
    chk("mult_issue_stop", 32'(Stop), 0);
    tick();
    set_ir(r_op(0, 0, 7, 6'b010010), r_op(2, 3, 0, 6'b011000), NOP);
    count_stalls(n);
    chk("mult_mflo_stalls", n, 5);
  endtask

  task automatic test_back_to_back();
    int n;
    do_reset();
    set_ir(r_op(2, 3, 0, 6'b011011), NOP, NOP);
    tick();
    set_ir(r_op(4, 5, 0, 6'b011001), r_op(2, 3, 0, 6'b011011), NOP);
    count_stalls(n);
    chk("b2b_multu_stalls", n, 10);
    tick();
    set_ir(r_op(6, 0, 0, 6'b010011), r_op(4, 5, 0, 6'b011001), NOP);
    count_stalls(n);
    chk("b2b_mtlo_stalls", n, 5);
  endtask

  task automatic test_reset_mid_div();
    do_reset();
    set_ir(r_op(2, 3, 0, 6'b011010), NOP, NOP);
    tick();
    set_ir(r_op(0, 0, 7, 6'b010010), r_op(2, 3, 0, 6'b011010), NOP);
    for (int i = 0; i < 4; i++) tick();
    chk("mid_div_busy", 32'(md_busy), 1);
    chk("mid_div_stall_cnt", 32'(stall_cnt), 4);
    reset = 1'b1;
    tick();
    reset = 1'b0;
    chk("mid_reset_busy", 32'(md_busy), 0);
    chk("mid_reset_stall_cnt", 32'(stall_cnt), 0);
    set_ir(r_op(0, 0, 7, 6'b010000), NOP, NOP);
    chk("mid_reset_mfhi", 32'(Stop), 0);
  endtask

  task automatic test_saturation();
    do_reset();
    set_ir(r_op(8, 1, 9, 6'b100001), i_op(6'b100011, 0, 8, 0), NOP);
    for (int i = 1; i <= 20; i++) begin
      tick();
      if (i == 3)  chk("sat_cnt_3", 32'(stall_cnt), 3);
      if (i == 15) chk("sat_cnt_15", 32'(stall_cnt), 15);
    end
    chk("sat_cnt_20", 32'(stall_cnt), 15);
    set_ir(NOP, NOP, NOP);
    tick();
    chk("sat_hold", 32'(stall_cnt), 15);
  endtask

  initial begin
    reset = 1'b1;
    IR_D = NOP; IR_E = NOP; IR_M = NOP;
    test_reset();
    test_load_use();
    test_branch();
    test_store_zero();
    test_mdu_window();
    test_back_to_back();
    test_reset_mid_div();
    test_saturation();
    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
